// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle controller: FSM states, opcodes,
// ALU operand/operation selects and the bundled control word.
package multicycle_control_pkg;

    localparam int OPCODE_W = 7;

    typedef enum logic [3:0] {
        ST_FETCH  = 4'd0,
        ST_DECODE = 4'd1,
        ST_EXEC_R = 4'd2,
        ST_ADDR   = 4'd3,
        ST_MEM_RD = 4'd4,
        ST_MEM_WR = 4'd5,
        ST_WB_ALU = 4'd6,
        ST_WB_MEM = 4'd7,
        ST_BRANCH = 4'd8,
        ST_TRAP   = 4'd9
    } state_t;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_SD  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_REGA  = 2'b10;

    localparam logic [1:0] SRCB_REGB    = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH1 = 2'b11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef struct packed {
        logic       ir_write;
        logic       pc_write;
        logic       pc_src;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       instr_done;
        logic       halted;
    } ctrl_t;

    // Opcode dispatch out of DECODE; anything unrecognised traps.
    function automatic state_t decode_next(input logic [6:0] opcode);
        state_t nxt;
        case (opcode)
            OP_R:         nxt = ST_EXEC_R;
            OP_LD, OP_SD: nxt = ST_ADDR;
            OP_BEQ:       nxt = ST_BRANCH;
            default:      nxt = ST_TRAP;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath bundle: instruction/flag inputs and control strobes.
interface multicycle_control_if;
    import multicycle_control_pkg::*;

    logic [OPCODE_W-1:0] opcode;
    logic                zero;
    logic                memReady;
    logic                irWrite;
    logic                pcWrite;
    logic                pcSrc;
    logic                memRead;
    logic                memWrite;
    logic                memToReg;
    logic                regWrite;
    logic [1:0]          aluSrcA;
    logic [1:0]          aluSrcB;
    logic [1:0]          aluOp;

    modport master (
        input  opcode, zero, memReady,
        output irWrite, pcWrite, pcSrc, memRead, memWrite, memToReg, regWrite,
               aluSrcA, aluSrcB, aluOp
    );

    modport slave (
        output opcode, zero, memReady,
        input  irWrite, pcWrite, pcSrc, memRead, memWrite, memToReg, regWrite,
               aluSrcA, aluSrcB, aluOp
    );

endinterface

// File: rtl/multicycle_control.sv
// Moore control FSM for a multicycle RISC-V style datapath with memory
// wait states, a sticky trap state and a retired-instruction counter.
module multicycle_control
    import multicycle_control_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    multicycle_control_if.master bus,
    output logic                 instrDone,
    output logic                 halted,
    output logic [3:0]           state,
    output logic [31:0]          instret
);

    state_t      state_r;
    state_t      next_state_s;
    logic [31:0] instret_r;
    ctrl_t       ctrl_s;
    ctrl_t       ctrl_q_s;

    // State register and retire counter; the counter wraps naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_FETCH;
            instret_r <= 32'd0;
        end else begin
            state_r <= next_state_s;
            if (ctrl_q_s.instr_done) begin
                instret_r <= instret_r + 32'd1;
            end else begin
                instret_r <= instret_r;
            end
        end
    end

    // Next-state and output decode from the current state.
    always_comb begin
        ctrl_s       = '0;
        next_state_s = ST_FETCH;
        case (state_r)
            ST_FETCH: begin
                ctrl_s.ir_write  = 1'b1;
                ctrl_s.pc_write  = 1'b1;
                ctrl_s.alu_src_a = SRCA_PC;
                ctrl_s.alu_src_b = SRCB_FOUR;
                ctrl_s.alu_op    = ALUOP_ADD;
                next_state_s     = ST_DECODE;
            end
            ST_DECODE: begin
                ctrl_s.alu_src_a = SRCA_OLDPC;
                ctrl_s.alu_src_b = SRCB_IMM_SH1;
                ctrl_s.alu_op    = ALUOP_ADD;
                next_state_s     = decode_next(bus.opcode);
            end
            ST_EXEC_R: begin
                ctrl_s.alu_src_a = SRCA_REGA;
                ctrl_s.alu_src_b = SRCB_REGB;
                ctrl_s.alu_op    = ALUOP_FUNCT;
                next_state_s     = ST_WB_ALU;
            end
            ST_ADDR: begin
                ctrl_s.alu_src_a = SRCA_REGA;
                ctrl_s.alu_src_b = SRCB_IMM;
                ctrl_s.alu_op    = ALUOP_ADD;
                next_state_s     = (bus.opcode == OP_LD) ? ST_MEM_RD : ST_MEM_WR;
            end
            ST_MEM_RD: begin
                ctrl_s.mem_read = 1'b1;
                next_state_s    = bus.memReady ? ST_WB_MEM : ST_MEM_RD;
            end
            ST_MEM_WR: begin
                ctrl_s.mem_write  = 1'b1;
                ctrl_s.instr_done = bus.memReady;
                next_state_s      = bus.memReady ? ST_FETCH : ST_MEM_WR;
            end
            ST_WB_ALU: begin
                ctrl_s.reg_write  = 1'b1;
                ctrl_s.instr_done = 1'b1;
                next_state_s      = ST_FETCH;
            end
            ST_WB_MEM: begin
                ctrl_s.reg_write  = 1'b1;
                ctrl_s.mem_to_reg = 1'b1;
                ctrl_s.instr_done = 1'b1;
                next_state_s      = ST_FETCH;
            end
            ST_BRANCH: begin
                // PC is only redirected when the compare says equal.
                ctrl_s.alu_src_a  = SRCA_REGA;
                ctrl_s.alu_src_b  = SRCB_REGB;
                ctrl_s.alu_op     = ALUOP_SUB;
                ctrl_s.pc_src     = 1'b1;
                ctrl_s.pc_write   = bus.zero;
                ctrl_s.instr_done = 1'b1;
                next_state_s      = ST_FETCH;
            end
            ST_TRAP: begin
                ctrl_s.halted = 1'b1;
                next_state_s  = ST_TRAP;
            end
            default: begin
                next_state_s = ST_FETCH;
            end
        endcase

        if (reset) begin
            ctrl_q_s = '0;
        end else begin
            ctrl_q_s = ctrl_s;
        end
    end

    assign bus.irWrite  = ctrl_q_s.ir_write;
    assign bus.pcWrite  = ctrl_q_s.pc_write;
    assign bus.pcSrc    = ctrl_q_s.pc_src;
    assign bus.memRead  = ctrl_q_s.mem_read;
    assign bus.memWrite = ctrl_q_s.mem_write;
    assign bus.memToReg = ctrl_q_s.mem_to_reg;
    assign bus.regWrite = ctrl_q_s.reg_write;
    assign bus.aluSrcA  = ctrl_q_s.alu_src_a;
    assign bus.aluSrcB  = ctrl_q_s.alu_src_b;
    assign bus.aluOp    = ctrl_q_s.alu_op;
    assign instrDone    = ctrl_q_s.instr_done;
    assign halted       = ctrl_q_s.halted;
    assign state        = state_r;
    assign instret      = instret_r;

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-high.
REQ-002 SHALL have ports: clk  in  1  rising-edge clock.
REQ-003 SHALL have ports: reset  in  1  synchronous active-high reset.
REQ-004 SHALL have ports: opcode  in  7  instruction[6:0] from the instruction register; zero  in  1  ALU zero flag; memReady  in  1  data-memory access complete.
REQ-005 SHALL have ports: irWrite, pcWrite, pcSrc, memRead, memWrite, memToReg, regWrite  out  1 each; aluSrcA  out  2  (00 PC, 01 oldPC, 10 regA); aluSrcB  out  2  (00 regB, 01 const 4, 10 imm, 11 imm<<1); aluOp  out  2  (00 add, 01 sub, 10 funct-decoded).
REQ-006 SHALL have ports: instrDone  out  1  retire pulse; halted  out  1  trap indicator; state  out  4  current state; instret  out  32  retired-instruction count.

Function
REQ-007 SHALL implement a Moore FSM with states FETCH=0, DECODE=1, EXEC_R=2, ADDR=3, MEM_RD=4, MEM_WR=5, WB_ALU=6, WB_MEM=7, BRANCH=8, TRAP=9; codes 10-15 SHALL go to FETCH.
REQ-008 FETCH: irWrite=1, pcWrite=1, pcSrc=0, aluSrcA=00, aluSrcB=01, aluOp=00; next DECODE.
REQ-009 DECODE: aluSrcA=01, aluSrcB=11, aluOp=00, so the branch target is registered as ALUOut; next state by opcode: 0110011->EXEC_R, 0000011 or 0100011->ADDR, 1100011->BRANCH, any other->TRAP.
REQ-010 EXEC_R: aluSrcA=10, aluSrcB=00, aluOp=10; next WB_ALU.
REQ-011 ADDR: aluSrcA=10, aluSrcB=10, aluOp=00; next MEM_RD if opcode=0000011, else MEM_WR.
REQ-012 MEM_RD: memRead=1 held; stay while memReady=0; next WB_MEM on memReady=1.
REQ-013 MEM_WR: memWrite=1 held; stay while memReady=0; on memReady=1, instrDone=1 and next FETCH.
REQ-014 WB_ALU: regWrite=1, memToReg=0; WB_MEM: regWrite=1, memToReg=1; both assert instrDone=1 and go to FETCH.
REQ-015 BRANCH: aluSrcA=10, aluSrcB=00, aluOp=01, pcSrc=1, pcWrite=zero (combinational); instrDone=1; next FETCH.
REQ-016 TRAP: halted=1, all other control outputs 0; stays in TRAP until reset.
REQ-017 Any output not listed for a state SHALL be 0.
REQ-018 Latency in cycles with zero wait: R-type 4, ld 5, sd 4, beq 3; each memReady=0 cycle adds one.
REQ-019 instret SHALL increment by 1 on every cycle with instrDone=1 and wrap from 0xFFFFFFFF to 0.
REQ-020 memReady outside MEM_RD/MEM_WR SHALL be ignored; opcode SHALL be sampled only in DECODE and ADDR.

Reset
REQ-021 While reset=1 at a clock edge, state SHALL become FETCH and instret SHALL become 0, regardless of current state, including mid-wait in MEM_RD/MEM_WR and in TRAP.
REQ-022 While reset=1, all control outputs, instrDone and halted SHALL be forced to 0.
REQ-023 The first cycle after reset deasserts SHALL be FETCH with irWrite=1 and pcWrite=1.

Structure
REQ-024 State encodings, opcode constants (R 0110011, LD 0000011, SD 0100011, BEQ 1100011) and aluSrcA/aluSrcB/aluOp encodings SHALL be defined in a shared package, also used by aluControl.
REQ-025 SHALL be one module with a registered state/instret and a single combinational output decoder; no sub-module.

Verification
REQ-026 Opcode 0110011, zero=0 -> states 0,1,2,6,0; regWrite=1 only in state 6; instret 0->1.
REQ-027 Opcode 0000011, memReady low 2 cycles then high -> 0,1,3,4,4,4,7,0; memRead=1 for exactly 3 cycles; memToReg=1 in state 7.
REQ-028 Opcode 1100011 with zero=1 then repeated with zero=0 -> pcWrite=1,pcSrc=1 in BRANCH first time, pcWrite=0 second; 3 cycles each.
REQ-029 Opcode 1111111 -> TRAP, halted=1 for 20 cycles, instret unchanged; reset pulse -> FETCH.
REQ-030 Preload instret to 0xFFFFFFFF via 2^32-1 instructions (or forced) then one R-type -> instret=0; reset asserted during MEM_WR wait -> FETCH next cycle, memWrite=0.
